// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: FSM/owner types and the byte-merge helper shared by ram_ctrl and its arbiter
package ram_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RD, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    localparam int MAX_SW = 32;
    localparam int MAX_W = MAX_SW * 8;
    // Bytes at or beyond sw are left as the old word; callers truncate to their own width.
    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0]  old_word,
        input logic [MAX_W-1:0]  new_word,
        input logic [MAX_SW-1:0] sel,
        input int                sw
    );
        logic [MAX_W-1:0] r;
        r = old_word;
        for (int k = 0; k < MAX_SW; k++)
            if (k < sw && sel[k]) r[k*8 +: 8] = new_word[k*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/ram_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on a tie the port that did not own last wins
module rr_arbiter2
    import ram_ctrl_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  owner_t     last,
    output logic [1:0] gnt
);
    always_comb gnt = (req_i && req_d) ? ((last == OWN_D) ? 2'b01 : 2'b10) : {req_d, req_i};
endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: arbitrates an instruction and a data port onto one RAM, with every data write done as read-modify-write
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter  int RAM_WORDS_SIZE  = 256,
    parameter  int RAM_WORDS_WIDTH = 32,
    localparam int AW = $clog2(RAM_WORDS_SIZE),
    localparam int SW = RAM_WORDS_WIDTH / 8
)(
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       i_req_i,
    input  logic [AW-1:0]              i_addr_i,
    output logic                       i_ack_o,
    output logic [RAM_WORDS_WIDTH-1:0] i_data_o,
    input  logic                       d_req_i,
    input  logic                       d_we_i,
    input  logic [SW-1:0]              d_sel_i,
    input  logic [AW-1:0]              d_addr_i,
    input  logic [RAM_WORDS_WIDTH-1:0] d_data_i,
    output logic                       d_ack_o,
    output logic [RAM_WORDS_WIDTH-1:0] d_data_o,
    output logic                       ram_we_o,
    output logic [AW-1:0]              ram_w_addr_o,
    output logic [AW-1:0]              ram_r_addr_o,
    output logic [RAM_WORDS_WIDTH-1:0] ram_data_o,
    input  logic [RAM_WORDS_WIDTH-1:0] ram_data_i
);
    state_t                     state;
    owner_t                     owner;
    owner_t                     last;
    logic [AW-1:0]              addr_q;
    logic                       we_q;
    logic [SW-1:0]              sel_q;
    logic [RAM_WORDS_WIDTH-1:0] wdata_q;
    logic [1:0]                 gnt;
    logic                       resp;
    logic [RAM_WORDS_WIDTH-1:0] merged;

    rr_arbiter2 u_arb (
        .req_i (i_req_i),
        .req_d (d_req_i),
        .last  (last),
        .gnt   (gnt)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            owner   <= OWN_I;
            last    <= OWN_D;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    owner   <= gnt[1] ? OWN_D : OWN_I;
                    last    <= gnt[1] ? OWN_D : OWN_I;
                    addr_q  <= gnt[1] ? d_addr_i : i_addr_i;
                    we_q    <= gnt[1] & d_we_i;
                    sel_q   <= gnt[1] ? d_sel_i : '0;
                    wdata_q <= gnt[1] ? d_data_i : '0;
                    state   <= RD;
                end
                RD:      state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    // Everything below depends only on registered state, never on live requests.
    always_comb begin
        resp         = state == RESP;
        i_ack_o      = resp && owner == OWN_I;
        d_ack_o      = resp && owner == OWN_D;
        ram_we_o     = resp && we_q;
        ram_r_addr_o = addr_q;
        ram_w_addr_o = addr_q;
        i_data_o     = i_ack_o ? ram_data_i : '0;
        d_data_o     = d_ack_o ? ram_data_i : '0;
        merged       = RAM_WORDS_WIDTH'(merge_bytes(MAX_W'(ram_data_i), MAX_W'(wdata_q), MAX_SW'(sel_q), SW));
        ram_data_o   = ram_we_o ? merged : '0;
    end
endmodule
